// File: rtl/mag_compare_seq_pkg.sv
// Shared types and elaboration helpers for the sequential magnitude comparator.
// Holds the FSM state, the 2-bit result code and the width legality check.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ   = 2'b00,
        RES_LT   = 2'b01,
        RES_GT   = 2'b10,
        RES_NONE = 2'b11
    } res_t;

    // Legal only when operands split into a whole number of non-empty slices.
    function automatic bit width_ok(input int width, input int slice);
        return (slice >= 1) && (width >= slice) && ((width % slice) == 0);
    endfunction

    // Full-equality resolution from the 7485-style cascade inputs, eq first.
    function automatic res_t cascade_res(input logic casc_eq, input logic casc_gt,
                                         input logic casc_lt);
        res_t res;
        if (casc_eq)
            res = RES_EQ;
        else if (casc_gt)
            res = RES_GT;
        else if (casc_lt)
            res = RES_LT;
        else
            res = RES_NONE;
        return res;
    endfunction

endpackage

// File: rtl/mag_compare_seq_slice_cmp.sv
// Combinational unsigned compare of one SLICE-bit slice pair.
module slice_cmp #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/mag_compare_seq.sv
// Sequential magnitude comparator: one slice per cycle, MSB slice first, early exit
// on the first differing slice, cascade inputs resolve full equality.
module mag_compare_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic             casc_lt,
    input  logic             casc_gt,
    input  logic             casc_eq,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int NSLICE = (SLICE >= 1) ? (WIDTH / SLICE) : 1;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (!width_ok(WIDTH, SLICE)) begin : g_bad_width
            $error("mag_compare_seq: WIDTH must be a non-zero multiple of SLICE >= 1");
        end
    endgenerate

    state_t            state_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              casc_lt_reg;
    logic              casc_gt_reg;
    logic              casc_eq_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              lt_reg;
    logic              gt_reg;
    logic              eq_reg;

    logic [SLICE-1:0]  a_sl [NSLICE];
    logic [SLICE-1:0]  b_sl [NSLICE];
    logic [SLICE-1:0]  cur_a;
    logic [SLICE-1:0]  cur_b;
    logic              sl_lt;
    logic              sl_gt;
    logic              sl_eq;
    logic              finish;
    res_t              res_next;

    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slices
            assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    assign cur_a = a_sl[idx_reg];
    assign cur_b = b_sl[idx_reg];

    slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .a  (cur_a),
        .b  (cur_b),
        .lt (sl_lt),
        .gt (sl_gt),
        .eq (sl_eq)
    );

    // A differing slice settles the order; an equal last slice defers to the cascade.
    always_comb begin
        res_next = RES_NONE;
        finish   = 1'b0;
        if (sl_gt) begin
            res_next = RES_GT;
            finish   = 1'b1;
        end else if (sl_lt) begin
            res_next = RES_LT;
            finish   = 1'b1;
        end else if (idx_reg == '0) begin
            res_next = cascade_res(casc_eq_reg, casc_gt_reg, casc_lt_reg);
            finish   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            casc_lt_reg <= 1'b0;
            casc_gt_reg <= 1'b0;
            casc_eq_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            lt_reg      <= 1'b0;
            gt_reg      <= 1'b0;
            eq_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Flipping both sign bits maps two's-complement order onto unsigned order.
                        a_reg       <= signed_mode ? (a ^ MSB_MASK) : a;
                        b_reg       <= signed_mode ? (b ^ MSB_MASK) : b;
                        casc_lt_reg <= casc_lt;
                        casc_gt_reg <= casc_gt;
                        casc_eq_reg <= casc_eq;
                        lt_reg      <= 1'b0;
                        gt_reg      <= 1'b0;
                        eq_reg      <= 1'b0;
                        idx_reg     <= IDXW'(NSLICE - 1);
                        busy_reg    <= 1'b1;
                        state_reg   <= CMP;
                    end
                end
                CMP: begin
                    if (finish) begin
                        lt_reg    <= (res_next == RES_LT);
                        gt_reg    <= (res_next == RES_GT);
                        eq_reg    <= (res_next == RES_EQ);
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign lt   = lt_reg;
    assign gt   = gt_reg;
    assign eq   = eq_reg;

endmodule

// File: tb/tb_mag_compare_seq.sv
// Directed and randomized checks of mag_compare_seq (WIDTH=16, SLICE=4) against an
// arithmetic reference model of result flags and latency.
module tb_mag_compare_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        signed_mode;
    logic        casc_lt;
    logic        casc_gt;
    logic        casc_eq;
    logic        busy;
    logic        done;
    logic        lt;
    logic        gt;
    logic        eq;

    int checks = 0;
    int errors = 0;

    mag_compare_seq #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .casc_lt     (casc_lt),
        .casc_gt     (casc_gt),
        .casc_eq     (casc_eq),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .gt          (gt),
        .eq          (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {lt,gt,eq} from numeric values of the operands.
    function automatic logic [2:0] ref_flags(input logic [15:0] av, input logic [15:0] bv,
                                             input logic sm, input logic ceq,
                                             input logic cgt, input logic clt);
        int va;
        int vb;
        va = int'(av);
        vb = int'(bv);
        if (sm) begin
            if (va >= 32768) va = va - 65536;
            if (vb >= 32768) vb = vb - 65536;
        end
        if (va < vb) return 3'b100;
        if (va > vb) return 3'b010;
        if (ceq)     return 3'b001;
        if (cgt)     return 3'b010;
        if (clt)     return 3'b100;
        return 3'b000;
    endfunction

    // Cycles to result: position of the first differing nibble from the top.
    function automatic int ref_lat(input logic [15:0] av, input logic [15:0] bv);
        for (int s = 3; s >= 0; s--) begin
            if (av[s*4 +: 4] != bv[s*4 +: 4]) return 4 - s;
        end
        return 4;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic await_done(input int max_cycles, output int lat);
        lat = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic run(input string name, input logic [15:0] av, input logic [15:0] bv,
                       input logic sm, input logic ceq, input logic cgt, input logic clt);
        logic [2:0] exp_f;
        int         exp_l;
        int         lat;
        exp_f = ref_flags(av, bv, sm, ceq, cgt, clt);
        exp_l = ref_lat(av, bv);
        @(negedge clk);
        a = av; b = bv; signed_mode = sm;
        casc_eq = ceq; casc_gt = cgt; casc_lt = clt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av; b = ~bv; signed_mode = ~sm;
        chk({name, ":busy_on"}, int'(busy), 1);
        chk({name, ":cleared"}, int'({lt, gt, eq}), 0);
        await_done(8, lat);
        chk({name, ":latency"}, lat, exp_l);
        chk({name, ":flags"}, int'({lt, gt, eq}), int'(exp_f));
        chk({name, ":busy_off"}, int'(busy), 0);
        @(posedge clk);
        #1;
        chk({name, ":done_pulse"}, int'(done), 0);
        chk({name, ":held"}, int'({lt, gt, eq}), int'(exp_f));
        $display("txn %s a=%04h b=%04h sm=%0d casc=%0d%0d%0d flags=%03b lat=%0d",
                 name, av, bv, sm, ceq, cgt, clt, {lt, gt, eq}, lat);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat;
        logic        seen_done;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        casc_lt = 1'b0; casc_gt = 1'b0; casc_eq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset:busy", int'(busy), 0);
        chk("reset:done", int'(done), 0);
        chk("reset:flags", int'({lt, gt, eq}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("early_gt",   16'h9000, 16'h1FFF, 1'b0, 1'b0, 1'b0, 1'b0);
        run("late_lt",    16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);
        run("eq_casc",    16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        run("signed_lt",  16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        run("unsig_gt",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run("casc_gtlt",  16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b1);
        run("casc_none",  16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0);
        run("casc_lt",    16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b1);
        run("signed_neg", 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Start re-pulsed mid-compare with other operands must be ignored.
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; signed_mode = 1'b0;
        casc_eq = 1'b0; casc_gt = 1'b0; casc_lt = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1; a = 16'hF000; b = 16'h0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignore:busy", int'(busy), 1);
        await_done(6, lat);
        chk("ignore:latency", lat, 2);
        chk("ignore:flags", int'({lt, gt, eq}), int'(ref_flags(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0)));
        $display("txn ignore flags=%03b lat_after_edge2=%0d", {lt, gt, eq}, lat);

        // Start held high: second compare accepted on the done cycle.
        @(negedge clk);
        a = 16'h9000; b = 16'h1FFF; signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("held:busy0", int'(busy), 1);
        @(posedge clk);
        #1;
        chk("held:done1", int'(done), 1);
        chk("held:flags1", int'({lt, gt, eq}), 3'b010);
        a = 16'h0001; b = 16'h0002;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("held:accept", int'(busy), 1);
        chk("held:cleared", int'({lt, gt, eq}), 0);
        await_done(8, lat);
        chk("held:latency", lat, ref_lat(16'h0001, 16'h0002));
        chk("held:flags2", int'({lt, gt, eq}), int'(ref_flags(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0)));
        $display("txn held_start flags=%03b lat=%0d", {lt, gt, eq}, lat);

        // Asynchronous reset in the middle of a 4-cycle compare.
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort:busy", int'(busy), 0);
        chk("abort:done", int'(done), 0);
        chk("abort:flags", int'({lt, gt, eq}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("abort:no_done", int'(seen_done), 0);
        $display("txn reset_abort busy=%0d done_seen=%0d", busy, seen_done);
        run("post_reset", 16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized operands, biased toward shared upper slices.
        for (int t = 0; t < 40; t++) begin
            ra = 16'($urandom);
            case ($urandom_range(2, 0))
                0: rb = 16'($urandom);
                1: rb = ra;
                default: rb = ra ^ (16'h1 << $urandom_range(15, 0));
            endcase
            run($sformatf("rand%0d", t), ra, rb, 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
